// File: rtl/shift_req_queue_pkg.sv
// rtl/shift_req_queue_pkg.sv - shared widths and request entry type for the shift request queue
package shift_req_queue_pkg;

    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amt;
    } req_entry_t;

endpackage

// File: rtl/shift_req_fifo.sv
// rtl/shift_req_fifo.sv - synchronous FIFO of shift request entries
module shift_req_fifo
    import shift_req_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  req_entry_t               push_entry,
    input  logic                     pop,
    output req_entry_t               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    req_entry_t      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Occupancy is tracked explicitly so full/empty never depend on pointer compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/shift_req_queue.sv
// rtl/shift_req_queue.sv - queued request front-end and response register for the barrel shifter
module shift_req_queue
    import shift_req_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [DATA_W-1:0]        req_data,
    input  logic [AMT_W-1:0]         req_amt,
    output logic [DATA_W-1:0]        sh_in,
    output logic [AMT_W-1:0]         sh_ctrl,
    input  logic [DATA_W-1:0]        sh_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [AMT_W-1:0]         rsp_amt,
    output logic [$clog2(DEPTH):0]   count
);

    req_entry_t push_entry;
    req_entry_t head;
    logic       full;
    logic       empty;
    logic       push;
    logic       load;

    // req_ready comes straight from registered occupancy; no path from rsp_ready.
    assign req_ready  = !full;
    assign push       = req_valid && req_ready;
    assign load       = !empty && (!rsp_valid || rsp_ready);
    assign push_entry = '{data: req_data, amt: req_amt};

    assign sh_in   = empty ? '0 : head.data;
    assign sh_ctrl = empty ? '0 : head.amt;

    shift_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (load),
        .head       (head),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    // Response register terminates the shifter's combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_amt   <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_data  <= sh_out;
            rsp_amt   <= head.amt;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_req_queue.sv
// tb/tb_shift_req_queue.sv - scoreboard testbench for shift_req_queue
module tb_shift_req_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_data;
    logic [2:0] req_amt;
    logic [7:0] sh_in;
    logic [2:0] sh_ctrl;
    logic [7:0] sh_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [2:0] rsp_amt;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q [$];
    logic [7:0]  rsp_log [$];
    int          mcount = 0;
    int          nfire = 0;
    logic        stall_prev = 1'b0;
    logic [7:0]  prev_data;
    logic [2:0]  prev_amt;
    logic        rand_done;

    always #5 clk = ~clk;

    // Reference shifter placed beside the block, as the integrating level would.
    assign sh_out = sh_in >> sh_ctrl;

    shift_req_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .sh_in     (sh_in),
        .sh_ctrl   (sh_ctrl),
        .sh_out    (sh_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_amt   (rsp_amt),
        .count     (count)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic       acc;
        logic       pop;
        logic [10:0] e;
        if (rst) begin
            exp_q.delete();
            mcount     = 0;
            stall_prev = 1'b0;
        end else begin
            check("count_model", int'(count), mcount);
            check("req_ready_model", int'(req_ready), int'(mcount != 4));
            if (stall_prev) begin
                check("stall_valid", int'(rsp_valid), 1);
                check("stall_data", int'(rsp_data), int'(prev_data));
                check("stall_amt", int'(rsp_amt), int'(prev_amt));
            end
            acc = req_valid && req_ready;
            if (acc) exp_q.push_back({8'(req_data >> req_amt), req_amt});
            if (rsp_valid && rsp_ready) begin
                nfire++;
                rsp_log.push_back(rsp_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: actual=0x%0h required=none", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", int'(rsp_data), int'(e[10:3]));
                    check("rsp_amt", int'(rsp_amt), int'(e[2:0]));
                end
            end
            pop    = (mcount != 0) && (!rsp_valid || rsp_ready);
            mcount = mcount + int'(acc) - int'(pop);
            stall_prev = rsp_valid && !rsp_ready;
            prev_data  = rsp_data;
            prev_amt   = rsp_amt;
        end
    end

    task automatic send(input logic [7:0] d, input logic [2:0] a);
        req_valid = 1'b1;
        req_data  = d;
        req_amt   = a;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: actual=req_ready 0 required=accept");
        req_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (count == 0 && !rsp_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: actual=count %0d required=0", count);
    endtask

    localparam logic [7:0] B2B_EXP [8] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};

    initial begin
        int n0;
        rst = 1'b1;
        req_valid = 1'b0;
        req_data = '0;
        req_amt = '0;
        rsp_ready = 1'b0;
        rand_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_data", int'(rsp_data), 0);
        check("rst_count", int'(count), 0);
        check("rst_sh_in", int'(sh_in), 0);
        rst = 1'b0;

        // Single request: latency and hand-computed result.
        rsp_ready = 1'b1;
        send(8'hB6, 3'd3);
        check("single_wait_valid", int'(rsp_valid), 0);
        check("single_count", int'(count), 1);
        check("single_sh_in", int'(sh_in), 8'hB6);
        check("single_sh_ctrl", int'(sh_ctrl), 3);
        @(posedge clk);
        #1;
        check("single_valid", int'(rsp_valid), 1);
        check("single_data", int'(rsp_data), 8'h16);
        check("single_amt", int'(rsp_amt), 3);
        check("single_count_after", int'(count), 0);
        drain();

        // Fill with response stalled.
        rsp_ready = 1'b0;
        send(8'h80, 3'd1);
        send(8'hF0, 3'd4);
        send(8'hAA, 3'd2);
        send(8'h01, 3'd0);
        send(8'hC3, 3'd7);
        check("fill_count", int'(count), 4);
        check("fill_req_ready", int'(req_ready), 0);
        check("fill_rsp_valid", int'(rsp_valid), 1);
        check("fill_rsp_data", int'(rsp_data), 8'h40);
        req_valid = 1'b1;
        req_data  = 8'h5A;
        req_amt   = 3'd5;
        repeat (3) @(posedge clk);
        #1;
        check("full_blocked_count", int'(count), 4);
        rsp_ready = 1'b1;
        #1;
        check("full_no_bypass", int'(req_ready), 0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("full_after_pulse", int'(count), 3);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("sixth_accepted", int'(count), 4);
        drain();

        // Back-to-back: all amounts twice on 0xFF.
        rsp_log.delete();
        n0 = nfire;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(8'hFF, 3'(i % 8));
        repeat (2) @(posedge clk);
        #1;
        check("b2b_throughput", nfire - n0, 16);
        for (int i = 0; i < 16; i++) begin
            if (i < rsp_log.size()) check("b2b_table", int'(rsp_log[i]), int'(B2B_EXP[i % 8]));
        end
        drain();

        // Random backpressure while pushing every cycle; wraps pointers many times.
        fork
            begin
                for (int i = 0; i < 40; i++) send(8'($urandom), 3'($urandom_range(0, 7)));
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();

        // Reset mid-stream with three queued and one response held.
        rsp_ready = 1'b0;
        send(8'h11, 3'd1);
        send(8'h22, 3'd2);
        send(8'h33, 3'd3);
        send(8'h44, 3'd4);
        check("pre_rst_count", int'(count), 3);
        check("pre_rst_valid", int'(rsp_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", int'(count), 0);
        check("async_rst_valid", int'(rsp_valid), 0);
        check("async_rst_ready", int'(req_ready), 1);
        check("async_rst_sh_ctrl", int'(sh_ctrl), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_rsp", int'(rsp_valid), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_req_queue.md
# shift_req_queue

Buffered request front-end for the 8-bit logical-right barrel shifter. It accepts shift requests (operand, 3-bit amount) over a valid/ready handshake and queues them in a small FIFO. It presents the oldest request to the combinational shifter and captures the shifter's result into a registered response stage with its own valid/ready handshake. It sits directly upstream of the shifter and also owns the register that terminates the shifter's combinational path.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  queue can accept; equals !full.
- req_data  in  8  operand to shift.
- req_amt  in  3  right-shift amount, 0–7.
- sh_in  out  8  operand driven to shifter data input.
- sh_ctrl  out  3  amount driven to shifter control input.
- sh_out  in  8  shifter result; combinational function of sh_in/sh_ctrl.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  8  shifted result.
- rsp_amt  out  3  amount used for this result.
- count  out  log2(DEPTH)+1  current FIFO occupancy.

## Operation
- Push: req_valid && req_ready at an edge writes {req_data, req_amt} at the write pointer and increments the write pointer modulo DEPTH.
- Head presentation:
  - FIFO non-empty: sh_in/sh_ctrl are driven combinationally from the head entry.
  - FIFO empty: sh_in/sh_ctrl are 0.
- Load condition, `load` = !empty && (!rsp_valid || rsp_ready).
- On load:
  - rsp_data ← sh_out; rsp_amt ← head amount; rsp_valid ← 1.
  - Head is popped; read pointer increments modulo DEPTH.
- Response fire without load (rsp_valid && rsp_ready && empty): rsp_valid ← 0; rsp_data/rsp_amt hold their last value.
- Stall: while rsp_valid && !rsp_ready, rsp_data/rsp_amt/rsp_valid hold and the FIFO does not pop.
- Occupancy: count increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- Full (count==DEPTH): req_ready=0, and no same-cycle bypass from rsp_ready to req_ready.
- Empty: there is no bypass from req to rsp; a request always spends at least one cycle in the FIFO.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are decoded from count, not pointer compare.
- Shift semantics (checked by scoreboard): rsp_data = req_data >> req_amt, zero-filled.
- Reset mid-operation discards all queued and in-flight requests. No partial response is ever emitted.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_amt=0, count=0, sh_in=0, sh_ctrl=0, pointers=0.
- Latency: a request pushed at edge N into an empty FIFO with an idle response stage is popped at edge N+1, so rsp_valid=1 during the cycle after edge N+1.
- Throughput: with rsp_ready held high, one response per cycle sustained.
- req_ready depends only on registered count, with no combinational input-to-output path on the request side.
- rsp_* are registered outputs.
- The only combinational path is head entry → sh_in/sh_ctrl → shifter → sh_out → rsp_data D-input, which must close within one cycle.

## Structure
- Shared package: DATA_W=8, AMT_W=3, request entry typedef {data[DATA_W-1:0], amt[AMT_W-1:0]}.
- One sub-module: shift_req_fifo.
  - Synchronous FIFO of request entries with push/pop/count/full/empty, parameterised by DEPTH.
  - Async active-high reset on pointers and count; the storage array is not reset.
- The top level holds the response register, load logic, and head-to-shifter drive.
- The shifter is instantiated beside this block by the integrating level, not inside it.

## Test plan
- Reset: assert rst mid-stream with 3 entries queued and rsp_valid=1. Required: immediately count=0, rsp_valid=0, req_ready=1, sh_ctrl=0; no response after release.
- Single request: req_data=0xB6, req_amt=3, rsp_ready=1. Required: rsp_valid one cycle after pop with rsp_data=0x16, rsp_amt=3; count returns to 0.
- Fill: rsp_ready=0, push 5 requests with DEPTH=4.
  - Required: first is loaded to rsp, next 4 fill the FIFO, count=4, req_ready=0.
  - 6th is not accepted until rsp_ready pulses.
  - Order is preserved.
- Back-to-back: 16 requests, amounts 0–7 twice, data 0xFF, rsp_ready=1. Required: one response per cycle, rsp_data = 0xFF>>amt (0xFF, 0x7F, …, 0x01).
- Stall and simultaneous push/pop:
  - Toggle rsp_ready randomly while pushing every cycle.
  - Required: rsp_data stable while stalled; count unchanged on push+pop cycles.
  - Scoreboard matches all results in order, including across pointer wrap.
